// File: rtl/board_key_reset_conditioner.sv
// board_key_reset_conditioner
//   Conditions asynchronous board push-buttons into debounced, active-high key
//   levels with one-cycle press/release pulses. It also generates the lab
//   system reset: a power-up pulse and, optionally, a reset triggered by
//   holding every key.
//
//   Optional feature macro: BOARD_KEY_COMBO_RESET_EN
//     defined   -> holding all keys for hold_cycles fires a por_cycles reset;
//                  the keys must all be released before it can fire again.
//     undefined -> only the power-up reset exists (POR -> RUN, RUN terminal).
//
//   Ports
//     clk          in   single clock, rising edge
//     rst_n        in   asynchronous active-low reset
//     key_raw      in   [w_key] raw board buttons (asynchronous)
//     key          out  [w_key] debounced level, active-high, order-mapped
//     key_pressed  out  [w_key] one-cycle pulse on debounced 0->1
//     key_released out  [w_key] one-cycle pulse on debounced 1->0
//     rst          out  active-high system reset
//     por_done     out  sticky, set when the first power-up pulse ends
module board_key_reset_conditioner #(
    parameter int unsigned w_key           = 2,
    parameter int unsigned debounce_cycles = 270000,
    parameter int unsigned por_cycles      = 2700000,
    parameter int unsigned hold_cycles     = 27000000,
    parameter int unsigned key_active_low  = 1,
    parameter int unsigned reverse_key     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [w_key-1:0] key_raw,
    output logic [w_key-1:0] key,
    output logic [w_key-1:0] key_pressed,
    output logic [w_key-1:0] key_released,
    output logic             rst,
    output logic             por_done
);

    localparam int unsigned DB_CW   = (debounce_cycles > 1) ? $clog2(debounce_cycles) : 1;
    localparam int unsigned CNT_MAX = (por_cycles > hold_cycles) ? por_cycles : hold_cycles;
    localparam int unsigned FSM_CW  = $clog2(CNT_MAX + 1);

    localparam logic [w_key-1:0]  RELEASED_LVL = (key_active_low != 0) ? {w_key{1'b1}} : {w_key{1'b0}};
    localparam logic [DB_CW-1:0]  DB_LAST      = DB_CW'(debounce_cycles - 1);
    localparam logic [FSM_CW-1:0] POR_LAST     = FSM_CW'(por_cycles - 1);
`ifdef BOARD_KEY_COMBO_RESET_EN
    localparam logic [FSM_CW-1:0] HOLD_LAST    = FSM_CW'(hold_cycles - 1);
`endif

    typedef enum logic [2:0] {
        ST_POR  = 3'd0,
        ST_RUN  = 3'd1,
        ST_HOLD = 3'd2,
        ST_RST  = 3'd3,
        ST_REL  = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; reset to the idle (released) raw level
    // ------------------------------------------------------------------
    logic [w_key-1:0] sync1_q, sync1_d;
    logic [w_key-1:0] sync2_q, sync2_d;
    logic [w_key-1:0] key_sample;

    always_comb begin
        sync1_d = key_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED_LVL;
            sync2_q <= RELEASED_LVL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Normalise to active-high "pressed"
    assign key_sample = (key_active_low != 0) ? ~sync2_q : sync2_q;

    // ------------------------------------------------------------------
    // Per-key debounce: stable flips after debounce_cycles differing samples
    // ------------------------------------------------------------------
    logic [w_key-1:0] stable_q;
    logic [w_key-1:0] stable_d;

    for (genvar g = 0; g < w_key; g++) begin : g_db
        logic [DB_CW-1:0] cnt_q, cnt_d;
        logic             stab_q, stab_d;

        always_comb begin
            cnt_d  = cnt_q;
            stab_d = stab_q;
            if (key_sample[g] == stab_q) begin
                cnt_d = '0;
            end else if (cnt_q == DB_LAST) begin
                stab_d = ~stab_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + DB_CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                stab_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                stab_q <= stab_d;
            end
        end

        assign stable_q[g] = stab_q;
        assign stable_d[g] = stab_d;
    end

    // ------------------------------------------------------------------
    // Output bit-order mapping of next level and edges
    // ------------------------------------------------------------------
    logic [w_key-1:0] key_map_c;
    logic [w_key-1:0] rise_map_c;
    logic [w_key-1:0] fall_map_c;

    for (genvar g = 0; g < w_key; g++) begin : g_map
        localparam int unsigned SRC = (reverse_key != 0) ? (w_key - 1 - g) : g;
        assign key_map_c[g]  = stable_d[SRC];
        assign rise_map_c[g] = stable_d[SRC] & ~stable_q[SRC];
        assign fall_map_c[g] = ~stable_d[SRC] & stable_q[SRC];
    end

    // ------------------------------------------------------------------
    // Reset FSM; decisions use the stable bits registered before the edge
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [FSM_CW-1:0] fsm_cnt_q, fsm_cnt_d;
    logic              rst_q, rst_d;
    logic              por_done_q, por_done_d;
    logic [w_key-1:0]  key_q, key_d;
    logic [w_key-1:0]  key_pressed_q, key_pressed_d;
    logic [w_key-1:0]  key_released_q, key_released_d;

`ifdef BOARD_KEY_COMBO_RESET_EN
    logic all_held;
    logic all_free;
    assign all_held = &stable_q;
    assign all_free = ~|stable_q;
`endif

    always_comb begin
        state_d    = state_q;
        fsm_cnt_d  = fsm_cnt_q;
        por_done_d = por_done_q;

        case (state_q)
            ST_POR: begin
                if (fsm_cnt_q == POR_LAST) begin
                    state_d    = ST_RUN;
                    fsm_cnt_d  = '0;
                    por_done_d = 1'b1;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + FSM_CW'(1);
                end
            end
            ST_RUN: begin
`ifdef BOARD_KEY_COMBO_RESET_EN
                if (all_held) begin
                    state_d   = ST_HOLD;
                    fsm_cnt_d = '0;
                end
`endif
            end
`ifdef BOARD_KEY_COMBO_RESET_EN
            ST_HOLD: begin
                if (!all_held) begin
                    state_d   = ST_RUN;
                    fsm_cnt_d = '0;
                end else if (fsm_cnt_q == HOLD_LAST) begin
                    state_d   = ST_RST;
                    fsm_cnt_d = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + FSM_CW'(1);
                end
            end
            ST_RST: begin
                if (fsm_cnt_q == POR_LAST) begin
                    state_d   = ST_REL;
                    fsm_cnt_d = '0;
                end else begin
                    fsm_cnt_d = fsm_cnt_q + FSM_CW'(1);
                end
            end
            // Wait for a full release so one long hold cannot re-trigger
            ST_REL: begin
                if (all_free) begin
                    state_d   = ST_RUN;
                    fsm_cnt_d = '0;
                end
            end
`endif
            default: begin
                state_d   = ST_POR;
                fsm_cnt_d = '0;
            end
        endcase

        rst_d = (state_d == ST_POR) || (state_d == ST_RST);

        // Pulses follow the next rst value so they are never seen under reset
        key_d          = key_map_c;
        key_pressed_d  = rst_d ? '0 : rise_map_c;
        key_released_d = rst_d ? '0 : fall_map_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_POR;
            fsm_cnt_q      <= '0;
            rst_q          <= 1'b1;
            por_done_q     <= 1'b0;
            key_q          <= '0;
            key_pressed_q  <= '0;
            key_released_q <= '0;
        end else begin
            state_q        <= state_d;
            fsm_cnt_q      <= fsm_cnt_d;
            rst_q          <= rst_d;
            por_done_q     <= por_done_d;
            key_q          <= key_d;
            key_pressed_q  <= key_pressed_d;
            key_released_q <= key_released_d;
        end
    end

    assign key          = key_q;
    assign key_pressed  = key_pressed_q;
    assign key_released = key_released_q;
    assign rst          = rst_q;
    assign por_done     = por_done_q;

endmodule
